// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the 4x4 tile game controller.
//   fsm_t        - controller sequencing states
//   dir_t        - slide direction
//   game_state_t - encoding of the 2-bit state output consumed by the renderer
//   line_idx()   - maps (direction, line, position-from-front) to a grid cell index
package game_pkg;

  localparam int GRID_N = 16;
  localparam int LINE_N = 4;
  localparam int EXP_W  = 4;

  localparam int unsigned WIN_EXP_DEF = 11;
  localparam logic [15:0] SEED_DEF    = 16'hACE1;

  typedef enum logic [2:0] {
    FSM_INIT,
    FSM_IDLE,
    FSM_MOVE,
    FSM_SPAWN,
    FSM_CHECK
  } fsm_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    GS_PLAY = 2'd0,
    GS_WON  = 2'd1,
    GS_LOST = 2'd2
  } game_state_t;

  // Cell k sits at row k/4, column k%4, so the index is {row, col}.
  // j = 0 is the front cell, i.e. the one tiles slide toward.
  function automatic logic [3:0] line_idx(dir_t dir, logic [1:0] i, logic [1:0] j);
    logic [1:0] jr;
    jr = 2'd3 - j;
    case (dir)
      DIR_UP:   line_idx = {j, i};
      DIR_DOWN: line_idx = {jr, i};
      DIR_LEFT: line_idx = {i, j};
      default:  line_idx = {i, jr};
    endcase
  endfunction

endpackage

// File: rtl/game_line_merge.sv
// line_merge: combinational slide-and-merge of one 4-cell line.
//   line_in  - 4 exponents, index 0 is the front cell
//   line_out - compacted, merged, compacted again
//   changed  - line_out differs from line_in
module line_merge
  import game_pkg::*;
(
  input  logic [LINE_N-1:0][EXP_W-1:0] line_in,
  output logic [LINE_N-1:0][EXP_W-1:0] line_out,
  output logic                         changed
);

  logic [LINE_N-1:0][EXP_W-1:0] compact_a;
  logic [LINE_N-1:0][EXP_W-1:0] merged;
  logic [1:0]                   n_a;
  logic [1:0]                   n_b;

  always_comb begin
    compact_a = '0;
    n_a       = '0;
    for (int j = 0; j < LINE_N; j++) begin
      if (line_in[j] != '0) begin
        compact_a[n_a] = line_in[j];
        n_a            = n_a + 2'd1;
      end
    end

    // A merged pair leaves a zero behind, so the zero cannot pair with the
    // next cell and no tile merges twice in one move.
    merged = compact_a;
    for (int j = 0; j < LINE_N - 1; j++) begin
      if (merged[j] != '0 && merged[j] == merged[j+1]) begin
        merged[j]   = (merged[j] == '1) ? merged[j] : merged[j] + 4'd1;
        merged[j+1] = '0;
      end
    end

    line_out = '0;
    n_b      = '0;
    for (int j = 0; j < LINE_N; j++) begin
      if (merged[j] != '0) begin
        line_out[n_b] = merged[j];
        n_b           = n_b + 2'd1;
      end
    end

    changed = (line_out != line_in);
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: sequencing controller for the 4x4 tile game.
//   clk, rst          - clock, synchronous active-high reset
//   btn_up/down/left/right - single-cycle direction presses
//   load, load_grid   - debug preload of the whole grid
//   grid              - 16 cell exponents, cell k = row k/4, col k%4
//   state             - 0 playing, 1 won, 2 lost
//   busy              - high whenever the controller is not idle
//
// state     | meaning
// ----------+-------------------------------------------------
// FSM_INIT  | place two starting tiles, one per cycle
// FSM_IDLE  | wait for load or a direction press
// FSM_MOVE  | slide/merge line 0..3, one line per cycle
// FSM_SPAWN | scan from a random cell for an empty one, fill it
// FSM_CHECK | evaluate win/lose, update state
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [15:0] SEED    = SEED_DEF,
  parameter int unsigned WIN_EXP = WIN_EXP_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        load,
  input  logic [GRID_N-1:0][EXP_W-1:0] load_grid,
  output logic [GRID_N-1:0][EXP_W-1:0] grid,
  output logic [1:0]                  state,
  output logic                        busy
);

  localparam logic [EXP_W-1:0] WIN_E = EXP_W'(WIN_EXP);

  fsm_t        fsm_q, fsm_d;
  dir_t        dir_q, cmd_dir;
  logic [1:0]  line_q;
  logic        moved_q;
  logic        init_q;
  logic [3:0]  scan_q;
  logic        spawn_two_q;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [1:0]  state_q;

  logic                         any_btn;
  logic [LINE_N-1:0][EXP_W-1:0] line_in, line_out;
  logic                         merge_changed;
  logic [3:0]                   init_idx;
  logic [EXP_W-1:0]             init_val;
  logic                         win, has_empty, has_pair;
  logic [1:0]                   check_state;

  assign state   = state_q;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    if (btn_up)        cmd_dir = DIR_UP;
    else if (btn_down) cmd_dir = DIR_DOWN;
    else if (btn_left) cmd_dir = DIR_LEFT;
    else               cmd_dir = DIR_RIGHT;
  end

  always_comb begin
    line_in = '0;
    for (int j = 0; j < LINE_N; j++)
      line_in[j] = grid[line_idx(dir_q, line_q, 2'(j))];
  end

  line_merge u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .changed  (merge_changed)
  );

  // The second starting tile steps past the first if the LFSR lands on it;
  // only one cell is occupied at that point, so one step is enough.
  assign init_idx = (grid[lfsr_q[3:0]] != '0) ? lfsr_q[3:0] + 4'd1 : lfsr_q[3:0];
  assign init_val = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;

  always_comb begin
    win       = 1'b0;
    has_empty = 1'b0;
    has_pair  = 1'b0;
    for (int k = 0; k < GRID_N; k++) begin
      if (grid[k] >= WIN_E) win = 1'b1;
      if (grid[k] == '0)    has_empty = 1'b1;
    end
    for (int r = 0; r < LINE_N; r++)
      for (int c = 0; c < LINE_N - 1; c++)
        if (grid[4*r+c] == grid[4*r+c+1]) has_pair = 1'b1;
    for (int k = 0; k < GRID_N - LINE_N; k++)
      if (grid[k] == grid[k+LINE_N]) has_pair = 1'b1;
    if (win)                         check_state = GS_WON;
    else if (!has_empty && !has_pair) check_state = GS_LOST;
    else                             check_state = GS_PLAY;
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= FSM_INIT;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    busy  = (fsm_q != FSM_IDLE);
    case (fsm_q)
      FSM_INIT:  if (init_q) fsm_d = FSM_CHECK;
      FSM_IDLE: begin
        if (load)                                fsm_d = FSM_CHECK;
        else if (any_btn && state_q == GS_PLAY) fsm_d = FSM_MOVE;
      end
      FSM_MOVE: begin
        if (line_q == 2'd3)
          fsm_d = (moved_q | merge_changed) ? FSM_SPAWN : FSM_CHECK;
      end
      FSM_SPAWN: if (grid[scan_q] == '0) fsm_d = FSM_CHECK;
      FSM_CHECK: fsm_d = FSM_IDLE;
      default:   fsm_d = FSM_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid        <= '0;
      state_q     <= GS_PLAY;
      lfsr_q      <= SEED;
      dir_q       <= DIR_UP;
      line_q      <= '0;
      moved_q     <= 1'b0;
      init_q      <= 1'b0;
      scan_q      <= '0;
      spawn_two_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      case (fsm_q)
        FSM_INIT: begin
          grid[init_idx] <= init_val;
          init_q         <= 1'b1;
        end
        FSM_IDLE: begin
          line_q  <= '0;
          moved_q <= 1'b0;
          dir_q   <= cmd_dir;
          if (load) grid <= load_grid;
        end
        FSM_MOVE: begin
          for (int j = 0; j < LINE_N; j++)
            grid[line_idx(dir_q, line_q, 2'(j))] <= line_out[j];
          moved_q     <= moved_q | merge_changed;
          line_q      <= line_q + 2'd1;
          // Last capture happens on the MOVE->SPAWN edge.
          scan_q      <= lfsr_q[3:0];
          spawn_two_q <= (lfsr_q[7:4] == 4'd0);
        end
        FSM_SPAWN: begin
          if (grid[scan_q] == '0) grid[scan_q] <= spawn_two_q ? 4'd2 : 4'd1;
          else                    scan_q <= scan_q + 4'd1;
        end
        FSM_CHECK: state_q <= check_state;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Sequencing controller for the 4x4 tile game. It owns the 16-cell grid of 4-bit tile exponents (0 = empty, n = tile value 2^n) and the 2-bit game state that the `graphics` renderer consumes. It accepts direction presses, slides and merges the grid one line per cycle, spawns a new tile, and evaluates win/lose. It replaces the constant grid/state drive used by the display bench.

## Interface
Parameters:
- `SEED`, 16'hACE1: LFSR reset value, must be nonzero.
- `WIN_EXP`, 11: exponent that wins the game (2048).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: debounced single-cycle press pulses.
- `load`  in  1: debug/test preload strobe.
- `load_grid`  in  16x4: grid image applied by `load`.
- `grid`  out  16x4: cell k = row k/4, column k%4, row 0 at top.
- `state`  out  2: 0 playing, 1 won, 2 lost; 3 is never driven.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - INIT: spawns two tiles, one per cycle, then goes to CHECK.
  - IDLE: waits for a command.
  - MOVE: takes 4 cycles, line index 0..3.
  - SPAWN: scans for an empty cell.
  - CHECK: takes 1 cycle, then returns to IDLE.
- Reset values: grid all 0, state=0, busy=1, FSM=INIT, LFSR=SEED.
- IDLE command priority: load > up > down > left > right. Only one command is taken per cycle.
- Direction presses are ignored when state≠0. Any input arriving while busy is dropped, not queued.
- `load`: takes effect in IDLE only, and regardless of state. grid←load_grid, then CHECK. No spawn follows a load.
- Line ordering, front cell first:
  - left: row i = cells 4i, 4i+1, 4i+2, 4i+3.
  - right: row i, reversed.
  - up: column i = cells i, i+4, i+8, i+12.
  - down: column i, reversed.
- Line merge, applied to one line per MOVE cycle:
  - Compact the nonzero cells toward the front.
  - Merge equal adjacent pairs from the front; each cell merges at most once. The merged exponent is e+1, saturating at 15.
  - Compact again and write back.
- Move tracking: a sticky `moved` flag sets if any written cell differs from its old value.
- End of MOVE: if moved, go to SPAWN; otherwise go to CHECK.
- SPAWN:
  - The scan starts at index lfsr[3:0] sampled on SPAWN entry and increments by 1 mod 16 each cycle.
  - At the first empty cell it writes 2 if lfsr[7:4]==0 (captured at entry), else 1, then goes to CHECK.
  - An empty cell always exists after a move, so SPAWN lasts at most 16 cycles.
- CHECK:
  - state←1 if any cell ≥ WIN_EXP.
  - Otherwise state←2 if there is no empty cell and no horizontally or vertically adjacent equal pair.
  - Otherwise state←0.
  - Won and lost are sticky until reset or load.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. It advances every cycle except during reset.

## Timing
- A press sampled in IDLE at cycle 0 sets busy=1 from cycle 1.
- Line i is written at the end of MOVE cycle i.
- Moving command: busy spans 4 (MOVE) + 1..16 (SPAWN) + 1 (CHECK) cycles.
- Non-moving command: busy spans exactly 5 cycles.
- The state output updates at the end of CHECK. busy falls in the same cycle that state becomes valid.
- Grid changes are visible to the renderer line by line mid-move; this is acceptable.
- Reset mid-operation: the next cycle has grid=0 and FSM=INIT, and any in-progress move is discarded.

## Structure
- `game_pkg` holds:
  - State encodings and the direction enum.
  - GRID_N=16, LINE_N=4, EXP_W=4.
  - WIN_EXP and SEED defaults.
  - Function `line_idx(dir, i, j)` returning the cell index.
- Sub-module `line_merge`: combinational; 4x4-bit in, 4x4-bit out plus `changed`. It is instantiated once and time-shared across the 4 MOVE cycles.
- The LFSR, win/lose detection and FSM live in `game_ctrl`.

## Test plan
- Load row0={1,1,2,2} with rows 1-3 zero, then left → row0={2,3,0,0}. Exactly one new cell appears, of value 1 or 2, in a previously empty cell; state=0.
- Load row0={1,1,1,1}, then right → row0={0,0,2,2}, not {0,0,0,3}.
- Load a full checkerboard of 1s and 2s → after CHECK, state=2. Any press is then ignored: grid unchanged, busy stays 0.
- Load row0={10,10,0,0}, then left → cell0=11 and state=1. Load with an all-zero grid → state=0.
- Load cell0=1 only, then left → grid unchanged, no spawn, busy high exactly 5 cycles.
- Assert btn_up and btn_left in the same cycle on a column-mergeable grid → the up result is applied.
- Assert rst during MOVE cycle 2 → next cycle grid=0, state=0, busy=1. Exactly two nonzero cells are present after INIT and CHECK.
